// File: rtl/pair_stream_gen.sv
// Half-shell pair feeder: walks a reference cell against a neighbour cell and
// streams every candidate (i, j) position pair, skipping i==j within one cell.
module pair_stream_gen #(
    parameter int POS_W  = 96,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   ref_count,
    input  logic [ADDR_W:0]   nbr_count,
    input  logic              same_cell,
    output logic              ref_rd_en,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [POS_W-1:0]  ref_rdata,
    output logic              nbr_rd_en,
    output logic [ADDR_W-1:0] nbr_addr,
    input  logic [POS_W-1:0]  nbr_rdata,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [POS_W-1:0]  pair_reference,
    output logic [POS_W-1:0]  pair_neighbor,
    output logic [ADDR_W-1:0] pair_ref_idx,
    output logic [ADDR_W-1:0] pair_nbr_idx,
    output logic              pair_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, REF_RD, REF_LD, NBR, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [POS_W-1:0]  ref_pos;
        logic [POS_W-1:0]  nbr_pos;
        logic [ADDR_W-1:0] ri;
        logic [ADDR_W-1:0] nj;
        logic              last;
    } pair_t;

    localparam logic [ADDR_W:0] ONE = 1;
    localparam logic [ADDR_W:0] TWO = 2;

    state_t            state, state_nx;
    logic [ADDR_W:0]   ref_cnt, nbr_cnt, i_q, i_nx, j_q, j_nx;
    logic              same_q;
    logic [POS_W-1:0]  ref_pos_q;
    logic              in_flight, tag_last;
    logic [ADDR_W-1:0] tag_i, tag_j;
    pair_t             fifo [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    pair_t             head;

    // Counts are ADDR_W+1 wide so a full cell (2^ADDR_W) never wraps the index compares.
    logic [ADDR_W:0] eff_n, ref_max, j_max, j_inc, j_skip;
    logic            row_end, job_end, pop, push, credit, issue;

    always_comb begin
        eff_n   = same_cell ? ref_count : nbr_count;
        ref_max = ref_cnt - ONE;
        j_max   = (same_q && i_q == ref_max) ? nbr_cnt - TWO : nbr_cnt - ONE;
        row_end = (j_q == j_max);
        job_end = row_end && (i_q == ref_max);
        j_inc   = j_q + ONE;
        j_skip  = (same_q && j_inc == i_q) ? j_q + TWO : j_inc;
        head    = fifo[rd_ptr];
        pop     = pair_valid & pair_ready;
        push    = in_flight;
        // Room for one more pair: buffered + in-flight, less whatever leaves this cycle.
        credit  = ({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});
        issue   = (state == NBR) && credit;
    end

    always_comb begin
        state_nx  = state;
        i_nx      = i_q;
        j_nx      = j_q;
        ref_rd_en = 1'b0;
        nbr_rd_en = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) begin
                i_nx = '0;
                if (ref_count == '0 || eff_n == '0 || (same_cell && ref_count == ONE))
                    state_nx = DONE;
                else
                    state_nx = REF_RD;
            end
            REF_RD: begin
                ref_rd_en = 1'b1;
                state_nx  = REF_LD;
            end
            REF_LD: begin
                j_nx     = (same_q && i_q == '0) ? ONE : '0;
                state_nx = NBR;
            end
            NBR: if (issue) begin
                nbr_rd_en = 1'b1;
                j_nx      = j_skip;
                if (row_end) begin
                    if (i_q < ref_max) begin
                        i_nx     = i_q + ONE;
                        state_nx = REF_RD;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: if (pop && head.last) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ref_cnt   <= '0;
            nbr_cnt   <= '0;
            same_q    <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            ref_pos_q <= '0;
            in_flight <= 1'b0;
            tag_i     <= '0;
            tag_j     <= '0;
            tag_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            i_q       <= i_nx;
            j_q       <= j_nx;
            in_flight <= issue;
            if (state == IDLE && start) begin
                ref_cnt <= ref_count;
                nbr_cnt <= eff_n;
                same_q  <= same_cell;
            end
            if (state == REF_LD) ref_pos_q <= ref_rdata;
            if (issue) begin
                tag_i    <= i_q[ADDR_W-1:0];
                tag_j    <= j_q[ADDR_W-1:0];
                tag_last <= job_end;
            end
        end
    end

    // Two-entry output FIFO; the credit check above guarantees it never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{ref_pos: ref_pos_q, nbr_pos: nbr_rdata,
                                  ri: tag_i, nj: tag_j, last: tag_last};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign ref_addr       = i_q[ADDR_W-1:0];
    assign nbr_addr       = j_q[ADDR_W-1:0];
    assign pair_valid     = (occ != '0);
    assign pair_reference = head.ref_pos;
    assign pair_neighbor  = head.nbr_pos;
    assign pair_ref_idx   = head.ri;
    assign pair_nbr_idx   = head.nj;
    assign pair_last      = head.last;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_pair_stream_gen.sv
// Directed bench for pair_stream_gen: memory models, handshake monitor and
// hand-built expected pair lists per job.
module tb_pair_stream_gen;
    localparam int POS_W = 96, ADDR_W = 8;

    logic              clk = 0, rst_n = 0, start = 0, same_cell = 0, pair_ready = 0;
    logic [ADDR_W:0]   ref_count = '0, nbr_count = '0;
    logic              ref_rd_en, nbr_rd_en, pair_valid, pair_last, busy, done;
    logic [ADDR_W-1:0] ref_addr, nbr_addr, pair_ref_idx, pair_nbr_idx;
    logic [POS_W-1:0]  ref_rdata = '0, nbr_rdata = '0, pair_reference, pair_neighbor;

    pair_stream_gen #(.POS_W(POS_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ref_count(ref_count),
        .nbr_count(nbr_count), .same_cell(same_cell),
        .ref_rd_en(ref_rd_en), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
        .nbr_rd_en(nbr_rd_en), .nbr_addr(nbr_addr), .nbr_rdata(nbr_rdata),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_reference(pair_reference), .pair_neighbor(pair_neighbor),
        .pair_ref_idx(pair_ref_idx), .pair_nbr_idx(pair_nbr_idx),
        .pair_last(pair_last), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [POS_W-1:0] refval(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {32'h3000_0000 | v, 32'h2000_0000 | v, 32'h1000_0000 | v};
    endfunction

    function automatic logic [POS_W-1:0] nbrval(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {32'hC000_0000 | v, 32'hB000_0000 | v, 32'hA000_0000 | v};
    endfunction

    // Synchronous memories; data is garbage except the cycle after a read.
    always @(posedge clk) begin
        ref_rdata <= ref_rd_en ? refval(int'(ref_addr)) : {POS_W{1'b1}};
        nbr_rdata <= nbr_rd_en ? nbrval(int'(nbr_addr)) : {POS_W{1'b1}};
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int ready_mode = 0, start_cyc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) pair_ready = 1'b1;
        else begin
            int rel;
            rel = cyc - start_cyc;
            if (rel >= 7 && rel < 12) pair_ready = 1'b0;
            else if (rel >= 12)       pair_ready = rel[0];
            else                      pair_ready = 1'b1;
        end
    end

    typedef struct {
        int              ri, nj;
        logic [POS_W-1:0] rp, np;
        logic            last;
    } rec_t;
    rec_t got[$];

    int   first_valid, done_cnt, done_cyc, last_hs_cyc, rd_cnt;
    int   outst = 0, credit_viol, self_viol, stall_viol, cur_ref = -1;
    logic same_mode = 0, prev_stall = 0;
    logic [2*POS_W+2*ADDR_W:0] prev_vec = '0;

    task automatic clear_stats();
        got.delete();
        first_valid = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; rd_cnt = 0;
        credit_viol = 0; self_viol = 0; stall_viol = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            outst = 0;
            prev_stall = 0;
        end else begin
            int pop;
            pop = (pair_valid && pair_ready) ? 1 : 0;
            if (pair_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && {pair_reference, pair_neighbor, pair_ref_idx, pair_nbr_idx, pair_last} != prev_vec)
                stall_viol++;
            if (prev_stall && !pair_valid) stall_viol++;
            prev_stall = pair_valid && !pair_ready;
            prev_vec = {pair_reference, pair_neighbor, pair_ref_idx, pair_nbr_idx, pair_last};
            if (pop == 1) begin
                got.push_back('{int'(pair_ref_idx), int'(pair_nbr_idx), pair_reference, pair_neighbor, pair_last});
                if (pair_last) last_hs_cyc = cyc;
            end
            if (ref_rd_en) begin
                cur_ref = int'(ref_addr);
                rd_cnt++;
            end
            if (nbr_rd_en) begin
                rd_cnt++;
                if (outst - pop >= 2) credit_viol++;
                if (same_mode && int'(nbr_addr) == cur_ref) self_viol++;
            end
            outst += (nbr_rd_en ? 1 : 0) - pop;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_job(input int rc, input int nc, input bit sm, input int rmode);
        clear_stats();
        ref_count = (ADDR_W+1)'(rc);
        nbr_count = (ADDR_W+1)'(nc);
        same_cell = sm;
        same_mode = sm;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_one_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Expected order built independently: i ascending, j ascending, no i==j for one cell.
    task automatic verify(input string tag, input int rc, input int nc, input bit sm);
        int n, bad, total, nn;
        rec_t r;
        nn = sm ? rc : nc;
        total = sm ? rc * (rc - 1) : rc * nc;
        n = 0;
        bad = 0;
        for (int i = 0; i < rc; i++)
            for (int j = 0; j < nn; j++)
                if (!(sm && i == j)) begin
                    if (n < got.size()) begin
                        r = got[n];
                        if (r.ri != i || r.nj != j || r.rp !== refval(i) || r.np !== nbrval(j)
                            || r.last !== (n == total - 1))
                            bad++;
                    end
                    n++;
                end
        chk({tag, "_count"}, 64'(got.size()), 64'(total));
        chk({tag, "_order_data"}, 64'(bad), 64'd0);
        chk({tag, "_credit"}, 64'(credit_viol), 64'd0);
        chk({tag, "_stable"}, 64'(stall_viol), 64'd0);
        chk({tag, "_done_after_last"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    endtask

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", 64'(|{ref_rd_en, nbr_rd_en, pair_valid, pair_last, done, ref_addr,
                               nbr_addr, pair_ref_idx, pair_nbr_idx, pair_reference, pair_neighbor}), 64'd0);
        rst_n = 1'b1;

        // 2x3 distinct cells
        start_job(2, 3, 0, 0);
        wait_done("t2x3", 200);
        verify("t2x3", 2, 3, 0);
        chk("t2x3_first_valid", 64'(first_valid - start_cyc), 64'd5);
        if (got.size() == 6) chk("t2x3_last_idx", 64'({got[5].ri, got[5].nj}), 64'({32'd1, 32'd2}));

        // same cell, 3 particles
        start_job(3, 7, 1, 0);
        wait_done("same3", 200);
        verify("same3", 3, 3, 1);
        chk("same3_no_self", 64'(self_viol), 64'd0);
        if (got.size() == 6) chk("same3_last_idx", 64'({got[5].ri, got[5].nj}), 64'({32'd2, 32'd1}));

        // 4x4 with stall and toggling ready
        start_job(4, 4, 0, 1);
        wait_done("stall4", 400);
        verify("stall4", 4, 4, 0);

        // degenerate jobs: no reads, done the cycle after start
        start_job(0, 5, 0, 0);
        wait_done("zero_ref", 20);
        chk("zero_ref_done_cyc", 64'(done_cyc - start_cyc), 64'd1);
        chk("zero_ref_no_rd", 64'(rd_cnt), 64'd0);
        chk("zero_ref_no_valid", 64'(first_valid), 64'(-1));
        start_job(1, 9, 1, 0);
        wait_done("same1", 20);
        chk("same1_done_cyc", 64'(done_cyc - start_cyc), 64'd1);
        chk("same1_no_rd", 64'(rd_cnt), 64'd0);
        chk("same1_no_valid", 64'(first_valid), 64'(-1));

        // reset mid-row, then a clean rerun
        start_job(4, 4, 0, 0);
        begin
            int n;
            n = 0;
            while (got.size() < 6 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rst_mid_reached", 64'(got.size() >= 6), 64'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'(|{busy, ref_rd_en, nbr_rd_en, pair_valid, pair_last, done, ref_addr,
                                   nbr_addr, pair_ref_idx, pair_nbr_idx, pair_reference, pair_neighbor}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        chk("rst_mid_idle", 64'(busy), 64'd0);
        start_job(4, 4, 0, 0);
        wait_done("rerun4", 200);
        verify("rerun4", 4, 4, 0);

        // full cells: 65536 pairs, no counter wrap
        start_job(256, 256, 0, 0);
        wait_done("full", 70000);
        verify("full", 256, 256, 0);
        if (got.size() > 0)
            chk("full_last_idx", 64'({got[got.size()-1].ri, got[got.size()-1].nj}), 64'({32'd255, 32'd255}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pair_stream_gen.md
Name: pair_stream_gen

Overview:
- Upstream feeder for the Newton's-third-law half-shell pair filter.
- Walks one reference cell and one neighbour cell held in synchronous cell-position memories, and emits every candidate (reference, neighbour) position pair on a valid/ready stream. Each position is a 96-bit {z,y,x} word, 32 bits per axis.
- Skips self-pairs when both memories hold the same cell, and marks the final pair of the job.
- Sustains one pair per cycle within a row under full ready.

Parameters:
POS_W, 96, packed position width ({z,y,x}, 32 bits per axis)
ADDR_W, 8, cell memory address width; max particles per cell = 2^ADDR_W

Ports:
clk  input  1  clock
rst_n  input  1  reset, active low
start  input  1  job request pulse; sampled only in IDLE
ref_count  input  ADDR_W+1  particles in reference cell; sampled at start
nbr_count  input  ADDR_W+1  particles in neighbour cell; sampled at start; ignored when same_cell=1
same_cell  input  1  reference and neighbour are the same cell; sampled at start
ref_rd_en  output  1  reference memory read strobe
ref_addr  output  ADDR_W  reference memory address
ref_rdata  input  POS_W  reference read data, valid 1 cycle after ref_rd_en
nbr_rd_en  output  1  neighbour memory read strobe
nbr_addr  output  ADDR_W  neighbour memory address
nbr_rdata  input  POS_W  neighbour read data, valid 1 cycle after nbr_rd_en
pair_valid  output  1  pair available
pair_ready  input  1  downstream accepts pair
pair_reference  output  POS_W  reference position
pair_neighbor  output  POS_W  neighbour position
pair_ref_idx  output  ADDR_W  reference index i
pair_nbr_idx  output  ADDR_W  neighbour index j
pair_last  output  1  final pair of job
busy  output  1  job in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` is asynchronous, active low.
- Reset: every output is 0; FSM in IDLE; output buffer and in-flight flag cleared. Reset asserted mid-job abandons the job silently, with no done pulse.
- FSM states: IDLE, REF_RD, REF_LD, NBR, DRAIN, DONE.
- IDLE:
  - start=1 latches counts and same_cell.
  - Effective neighbour count N = same_cell ? ref_count : nbr_count.
  - If ref_count==0, N==0, or (same_cell and ref_count==1), go to DONE with no memory reads. Otherwise set i=0 and go to REF_RD.
  - start is ignored outside IDLE.
- REF_RD: ref_rd_en=1, ref_addr=i; go to REF_LD.
- REF_LD: ref_rdata captured into the reference register; j = first valid index (0, or 1 if same_cell and i==0); go to NBR.
- NBR: issue nbr_rd_en=1, nbr_addr=j when credit allows.
  - Credit: occupancy + in_flight − pop < 2, where pop = pair_valid & pair_ready.
  - Each issue tags i, j and last = (i==ref_count−1 and j is the final valid j of the row).
  - After issue, advance j, skipping j==i when same_cell.
  - After the final j of a row: if i<ref_count−1, increment i and go to REF_RD; else go to DRAIN.
- Pair formation: the cycle after issue, nbr_rdata plus the reference register plus the tags are written into a 2-entry FIFO. The reference register is not overwritten until REF_LD, which is at least 2 cycles after the last issue of a row, so no hazard.
- Output stream:
  - The FIFO head drives the pair_* outputs; pair_valid = FIFO non-empty.
  - Contents are stable while pair_valid & !pair_ready.
  - Never drop or duplicate a pair; a push and a pop in the same cycle are both honoured.
- DRAIN: waits for the handshake of the pair with pair_last=1, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE).
- Pair order: i ascending, then j ascending.
- Latency and throughput:
  - start at cycle 0 → ref_rd_en at cycle 1 → first nbr_rd_en at cycle 3 → first pair_valid at cycle 5.
  - Within a row, one pair per cycle with pair_ready=1.
  - Row transition costs a 2-cycle bubble on pair_valid.
- Counts at the maximum value (2^ADDR_W): index counters must not wrap before termination. Compare against count−1 in ADDR_W+1 bits.

Test Plan:
- ref_count=2, nbr_count=3, same_cell=0, ready=1 → pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with matching memory data; pair_last only on (1,2); done one cycle after its handshake; first pair_valid at cycle 5.
- same_cell=1, ref_count=3 → pairs (0,1),(0,2),(1,0),(1,2),(2,0),(2,1); no j==i ever issued; pair_last on (2,1).
- 4×4 job, pair_ready low 5 cycles mid-row, then toggling 1/0 → pair_* held stable while stalled; nbr_rd_en low once occupancy+in_flight=2; all 16 pairs delivered exactly once, in order.
- ref_count=0, and separately same_cell=1 with ref_count=1 → no ref_rd_en/nbr_rd_en; done=1 the cycle after start; pair_valid never asserted.
- rst_n pulsed low mid-row of a 4×4 job → all outputs 0 immediately; no done; a new start then yields the full 16 pairs.
- ref_count=nbr_count=2^ADDR_W, ready=1 → exactly 2^(2·ADDR_W) pairs, last pair (255,255), clean termination without wrap.
